ex_hazard_ctrl: RTL and testbench
=================================

Name: ex_hazard_ctrl

Overview:
- Pipeline controller for the EX/MEM datapath. Tracks destination registers of the instructions in EX, MEM and WB.
- Computes the registered operand-forwarding selects and the ALU-operand selects for each instruction entering EX.
- Detects load-use hazards and sequences multi-cycle EX operations (mul/div) by stalling the front end and holding EX.
- Sits between ID decode and the EX/MEM stage; drives that stage's mux selects, alu_ctrl, rd_addr_ex and wb_en_ex.

Parameters:
- MDIV_LAT, 4, total EX occupancy in cycles of a multi-cycle op (legal range 2..15).
- CNT_W, 32, width of performance counters (optional feature only).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  valid instruction in ID
- id_rs1_addr  in  5  ID source 1
- id_rs2_addr  in  5  ID source 2
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- id_rd_addr  in  5  ID destination register
- id_wb_en  in  1  ID instruction writes rd
- id_is_load  in  1  ID instruction is a load
- id_is_mdiv  in  1  ID instruction is multi-cycle
- id_use_imm  in  1  ALU src2 is the immediate
- id_alu_ctrl  in  1  ALU op select
- flush  in  1  branch redirect; kill ID and EX
- mux1_sel  out  2  EX src1 select: 00 reg, 01 MEM fwd, 10 WB fwd, 11 late regfile read
- mux2_sel  out  2  EX src2 select, same encoding
- mux3_sel  out  1  EX src1 stage-2 select, always 0
- mux4_sel  out  1  EX src2 stage-2 select (1 = imm)
- alu_ctrl  out  1  registered ALU op
- rd_addr_ex  out  5  rd of the instruction in EX
- wb_en_ex  out  1  write enable of the instruction in EX (0 for a bubble)
- stall_if_id  out  1  freeze PC and IF/ID
- ex_hold  out  1  freeze the EX/MEM register (multi-cycle in progress)

Behaviour:
- Reset: all outputs 0; internal EX/MEM/WB tracking (rd, wb_en, is_load, is_mdiv) cleared; mdiv counter 0; FSM in RUN.
- Internal tracking pipeline: ex_* ← ID fields on advance; mem_* ← ex_*; wb_* ← mem_*.
  - While ex_hold=1: EX and MEM fields frozen; WB takes a bubble (wb_en 0).
- Forward select per source, computed in ID and registered on advance. Priority, first match wins:
  - EX rd match → 01
  - else MEM rd match → 10
  - else WB rd match → 11
  - else 00
  - A match requires the stage wb_en=1, rd≠0, the matching source used, and id_valid.
  - x0 never forwards.
- Load-use: ex_is_load & ex_wb_en & rd≠0 & used-source match in ID.
  - stall_if_id=1 for one cycle (combinational).
  - EX gets a bubble: wb_en_ex 0, selects 00.
  - Next cycle the instruction advances with select 10.
- FSM states: RUN, MDIV.
  - RUN→MDIV when an mdiv instruction enters EX; counter loaded with MDIV_LAT-1.
  - In MDIV: ex_hold=1 and stall_if_id=1; counter decrements each cycle.
  - MDIV→RUN when the counter reaches 1; ex_hold drops the cycle the counter is 0.
  - Total EX occupancy is exactly MDIV_LAT cycles.
- flush: next EX is a bubble; ID not captured.
  - flush wins over load-use stall.
  - flush during MDIV is ignored; the op completes and flush must be held by the front end.
- Simultaneous load-use and MDIV: MDIV hold dominates; the load-use check is re-evaluated after MDIV exits.
- Reset mid-MDIV: immediate return to RUN, all outputs 0.
- mux3_sel is constant 0. mux4_sel and alu_ctrl are registered from id_use_imm and id_alu_ctrl; they are 0 for a bubble.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined: adds outputs perf_lu_stalls [CNT_W-1:0] and perf_mdiv_cycles [CNT_W-1:0].
  - perf_lu_stalls counts load-use stall cycles; perf_mdiv_cycles counts ex_hold cycles.
  - Both saturate at all-ones and are cleared by rst.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- After reset, back-to-back add x5 then add x6,x5,x5 → second instruction in EX with mux1_sel=01, mux2_sel=01, no stall.
- lw x7; nop; add x8,x7,x0 → add in EX with mux1_sel=10.
- lw x7 then add x8,x7,x0 → stall_if_id=1 for 1 cycle; bubble (wb_en_ex=0); add then in EX with mux1_sel=10.
- Writes to x0 followed by reads of x0 → mux sels stay 00, no stall.
- MDIV_LAT=4: div followed by add → ex_hold=1 for 3 cycles; div occupies EX for exactly 4 cycles; add enters on cycle 5.
- rst asserted mid-MDIV → ex_hold, stall_if_id and all outputs 0 asynchronously.
- With HAZ_PERF_CNT_EN defined: after the two scenarios above, perf_lu_stalls=1 and perf_mdiv_cycles=3.

Source files
------------

// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: hazard and sequencing controller for the EX/MEM stage.
// Tracks destination registers through EX, MEM and WB. Registers the operand
// forwarding selects and ALU-operand selects for each instruction that enters
// EX. Detects load-use hazards and holds EX for the full latency of
// multi-cycle (mul/div) operations.
//
// Handshake: an instruction in ID with id_valid=1 is consumed on a rising edge
// only when stall_if_id=0 and flush=0. Otherwise the front end must present
// the same instruction again. ex_hold=1 means the EX/MEM register keeps its
// contents across that edge.
//
// Optional build macro HAZ_PERF_CNT_EN adds the saturating performance
// counters perf_lu_stalls and perf_mdiv_cycles.
module ex_hazard_ctrl #(
    parameter int MDIV_LAT = 4,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd_addr,
    input  logic             id_wb_en,
    input  logic             id_is_load,
    input  logic             id_is_mdiv,
    input  logic             id_use_imm,
    input  logic             id_alu_ctrl,
    input  logic             flush,
    output logic [1:0]       mux1_sel,
    output logic [1:0]       mux2_sel,
    output logic             mux3_sel,
    output logic             mux4_sel,
    output logic             alu_ctrl,
    output logic [4:0]       rd_addr_ex,
    output logic             wb_en_ex,
    output logic             stall_if_id,
    output logic             ex_hold
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_lu_stalls,
    output logic [CNT_W-1:0] perf_mdiv_cycles
`endif
);

    // Parameter sanity: the occupancy counter is 4 bits wide.
    if (MDIV_LAT < 2 || MDIV_LAT > 15 || CNT_W < 1) begin : g_bad_params
        $error("ex_hazard_ctrl: MDIV_LAT must be 2..15 and CNT_W >= 1");
    end

    localparam logic [3:0] CNT_LOAD = 4'(MDIV_LAT - 1);

    typedef enum logic {
        RUN  = 1'b0,
        MDIV = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] mdiv_cnt, mdiv_cnt_nxt;

    // Destination tracking for the three downstream stages.
    logic [4:0] ex_rd, mem_rd, wb_rd;
    logic       ex_wb_en, mem_wb_en, wb_wb_en;
    logic       ex_is_load;

    logic       hold;
    logic       lu_hit;
    logic       lu_stall;
    logic       capture;
    logic [1:0] fwd1, fwd2;

    // First match wins: EX (result will sit in MEM) -> 01, MEM -> 10, WB -> 11.
    // x0 never matches because rs must be non-zero.
    function automatic logic [1:0] fwd_sel(
        input logic       valid,
        input logic       use_rs,
        input logic [4:0] rs,
        input logic       e_w,
        input logic [4:0] e_r,
        input logic       m_w,
        input logic [4:0] m_r,
        input logic       w_w,
        input logic [4:0] w_r
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (valid && use_rs && rs != 5'd0) begin
            if (e_w && e_r == rs)      sel = 2'b01;
            else if (m_w && m_r == rs) sel = 2'b10;
            else if (w_w && w_r == rs) sel = 2'b11;
        end
        return sel;
    endfunction

    // Hazard detection, stall generation and forward-select computation.
    always_comb begin
        hold   = (state == MDIV);
        lu_hit = ex_is_load && ex_wb_en && (ex_rd != 5'd0) && id_valid &&
                 ((id_use_rs1 && id_rs1_addr == ex_rd) ||
                  (id_use_rs2 && id_rs2_addr == ex_rd));
        // A redirect kills the dependent instruction, so no stall is needed;
        // during a multi-cycle op the hold already covers the front end.
        lu_stall    = lu_hit && !hold && !flush;
        stall_if_id = hold || lu_stall;
        ex_hold     = hold;
        capture     = !hold && id_valid && !flush && !lu_hit;
        fwd1 = fwd_sel(id_valid, id_use_rs1, id_rs1_addr, ex_wb_en, ex_rd,
                       mem_wb_en, mem_rd, wb_wb_en, wb_rd);
        fwd2 = fwd_sel(id_valid, id_use_rs2, id_rs2_addr, ex_wb_en, ex_rd,
                       mem_wb_en, mem_rd, wb_wb_en, wb_rd);
    end

    // Multi-cycle sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            mdiv_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            mdiv_cnt <= mdiv_cnt_nxt;
        end
    end

    // Sequencer next state: enter MDIV as a mul/div is captured into EX and
    // leave after MDIV_LAT-1 held cycles, so EX is occupied MDIV_LAT cycles.
    always_comb begin
        state_nxt    = state;
        mdiv_cnt_nxt = mdiv_cnt;
        case (state)
            RUN: begin
                if (capture && id_is_mdiv) begin
                    state_nxt    = MDIV;
                    mdiv_cnt_nxt = CNT_LOAD;
                end
            end
            MDIV: begin
                mdiv_cnt_nxt = mdiv_cnt - 4'd1;
                if (mdiv_cnt == 4'd1) state_nxt = RUN;
            end
            default: begin
                state_nxt    = RUN;
                mdiv_cnt_nxt = 4'd0;
            end
        endcase
    end

    // Stage tracking and registered EX controls. On hold, EX and MEM keep
    // their contents while WB receives a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_rd      <= 5'd0;
            ex_wb_en   <= 1'b0;
            ex_is_load <= 1'b0;
            mem_rd     <= 5'd0;
            mem_wb_en  <= 1'b0;
            wb_rd      <= 5'd0;
            wb_wb_en   <= 1'b0;
            mux1_sel   <= 2'b00;
            mux2_sel   <= 2'b00;
            mux4_sel   <= 1'b0;
            alu_ctrl   <= 1'b0;
        end else if (hold) begin
            wb_rd    <= 5'd0;
            wb_wb_en <= 1'b0;
        end else begin
            wb_rd     <= mem_rd;
            wb_wb_en  <= mem_wb_en;
            mem_rd    <= ex_rd;
            mem_wb_en <= ex_wb_en;
            if (capture) begin
                ex_rd      <= id_rd_addr;
                ex_wb_en   <= id_wb_en;
                ex_is_load <= id_is_load;
                mux1_sel   <= fwd1;
                mux2_sel   <= fwd2;
                mux4_sel   <= id_use_imm;
                alu_ctrl   <= id_alu_ctrl;
            end else begin
                ex_rd      <= 5'd0;
                ex_wb_en   <= 1'b0;
                ex_is_load <= 1'b0;
                mux1_sel   <= 2'b00;
                mux2_sel   <= 2'b00;
                mux4_sel   <= 1'b0;
                alu_ctrl   <= 1'b0;
            end
        end
    end

    assign mux3_sel   = 1'b0;
    assign rd_addr_ex = ex_rd;
    assign wb_en_ex   = ex_wb_en;

`ifdef HAZ_PERF_CNT_EN
    // Saturating counters of load-use stall cycles and EX hold cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_lu_stalls   <= '0;
            perf_mdiv_cycles <= '0;
        end else begin
            if (lu_stall && perf_lu_stalls != '1)
                perf_lu_stalls <= perf_lu_stalls + CNT_W'(1);
            if (hold && perf_mdiv_cycles != '1)
                perf_mdiv_cycles <= perf_mdiv_cycles + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl with an expected-output queue.
// Each cycle the driver applies ID inputs and pushes the output vector it
// expects for that cycle; a negedge monitor pops and compares.
module tb_ex_hazard_ctrl;
    localparam int W = 15;
    localparam logic [W-1:0] Z = '0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid, id_use_rs1, id_use_rs2, id_wb_en, id_is_load;
    logic       id_is_mdiv, id_use_imm, id_alu_ctrl, flush;
    logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [1:0] mux1_sel, mux2_sel;
    logic       mux3_sel, mux4_sel, alu_ctrl, wb_en_ex, stall_if_id, ex_hold;
    logic [4:0] rd_addr_ex;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_lu_stalls, perf_mdiv_cycles;
`endif

    // clock
    always #5 clk = ~clk;

    ex_hazard_ctrl #(.MDIV_LAT(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd_addr(id_rd_addr),
        .id_wb_en(id_wb_en), .id_is_load(id_is_load), .id_is_mdiv(id_is_mdiv),
        .id_use_imm(id_use_imm), .id_alu_ctrl(id_alu_ctrl), .flush(flush),
        .mux1_sel(mux1_sel), .mux2_sel(mux2_sel), .mux3_sel(mux3_sel),
        .mux4_sel(mux4_sel), .alu_ctrl(alu_ctrl), .rd_addr_ex(rd_addr_ex),
        .wb_en_ex(wb_en_ex), .stall_if_id(stall_if_id), .ex_hold(ex_hold)
`ifdef HAZ_PERF_CNT_EN
        , .perf_lu_stalls(perf_lu_stalls), .perf_mdiv_cycles(perf_mdiv_cycles)
`endif
    );

    logic [W-1:0] act;
    assign act = {mux1_sel, mux2_sel, mux3_sel, mux4_sel, alu_ctrl,
                  rd_addr_ex, wb_en_ex, stall_if_id, ex_hold};

    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_e;
    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    function automatic logic [W-1:0] mk(input int m1, input int m2, input int m4,
                                        input int alu, input int rd, input int wb,
                                        input int st, input int hd);
        return {2'(m1), 2'(m2), 1'b0, 1'(m4), 1'(alu), 5'(rd), 1'(wb), 1'(st), 1'(hd)};
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        cyc_n = cyc_n + 1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (act !== mon_e) begin
                errors++;
                $display("FAIL outvec cycle %0d actual=%b required=%b (m1 m2 m3 m4 alu rd wb stall hold)",
                         cyc_n, act, mon_e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        id_valid = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_use_rs1 = 0;
        id_use_rs2 = 0; id_rd_addr = 0; id_wb_en = 0; id_is_load = 0;
        id_is_mdiv = 0; id_use_imm = 0; id_alu_ctrl = 0; flush = 0;
    endtask

    task automatic ins(input int rd, input int rs1, input int rs2, input int u1,
                       input int u2, input int wb, input int ld, input int md,
                       input int imm, input int alu);
        id_valid = 1; id_rd_addr = 5'(rd); id_rs1_addr = 5'(rs1); id_rs2_addr = 5'(rs2);
        id_use_rs1 = 1'(u1); id_use_rs2 = 1'(u2); id_wb_en = 1'(wb);
        id_is_load = 1'(ld); id_is_mdiv = 1'(md); id_use_imm = 1'(imm);
        id_alu_ctrl = 1'(alu); flush = 0;
    endtask

    task automatic push_exp(input logic [W-1:0] e);
        exp_q.push_back(e);
    endtask

`ifdef HAZ_PERF_CNT_EN
    task automatic chk_perf(input logic [31:0] lu, input logic [31:0] md);
        checks++;
        if (perf_lu_stalls !== lu) begin
            errors++;
            $display("FAIL perf_lu_stalls actual=%0d required=%0d", perf_lu_stalls, lu);
        end
        checks++;
        if (perf_mdiv_cycles !== md) begin
            errors++;
            $display("FAIL perf_mdiv_cycles actual=%0d required=%0d", perf_mdiv_cycles, md);
        end
    endtask
`endif

    // driver
    initial begin
        nop();
        rst = 1;
        tick(); push_exp(Z);
        tick(); push_exp(Z);
        tick(); rst = 0; push_exp(Z);

        // add x5; add x6,x5,x5 -> EX forward 01/01
        tick(); ins(5, 1, 2, 1, 1, 1, 0, 0, 0, 0); push_exp(Z);
        tick(); ins(6, 5, 5, 1, 1, 1, 0, 0, 0, 1); push_exp(mk(0, 0, 0, 0, 5, 1, 0, 0));
        tick(); nop();                             push_exp(mk(1, 1, 0, 1, 6, 1, 0, 0));
        // add x10,x5,x6 with x5 in WB, x6 in MEM -> 11/10
        tick(); ins(10, 5, 6, 1, 1, 1, 0, 0, 0, 0); push_exp(Z);
        tick(); nop();                              push_exp(mk(3, 2, 0, 0, 10, 1, 0, 0));
        tick(); nop(); push_exp(Z);
        tick(); nop(); push_exp(Z);
        tick(); nop(); push_exp(Z);

        // x0 writes then x0 reads: no forwarding, no load-use stall
        tick(); ins(0, 1, 1, 1, 1, 1, 0, 0, 0, 0); push_exp(Z);
        tick(); ins(3, 0, 0, 1, 1, 1, 0, 0, 0, 0); push_exp(mk(0, 0, 0, 0, 0, 1, 0, 0));
        tick(); ins(0, 2, 0, 1, 0, 1, 1, 0, 1, 0); push_exp(mk(0, 0, 0, 0, 3, 1, 0, 0));
        tick(); ins(4, 0, 0, 1, 0, 1, 0, 0, 0, 0); push_exp(mk(0, 0, 1, 0, 0, 1, 0, 0));
        tick(); nop();                             push_exp(mk(0, 0, 0, 0, 4, 1, 0, 0));
        tick(); nop(); push_exp(Z);
        tick(); nop(); push_exp(Z);
        tick(); nop(); push_exp(Z);

        // lw x7; nop; add x8,x7,x0 -> MEM forward 10, no stall
        tick(); ins(7, 1, 0, 1, 0, 1, 1, 0, 1, 0); push_exp(Z);
        tick(); nop();                             push_exp(mk(0, 0, 1, 0, 7, 1, 0, 0));
        tick(); ins(8, 7, 0, 1, 1, 1, 0, 0, 0, 0); push_exp(Z);
        tick(); nop();                             push_exp(mk(2, 0, 0, 0, 8, 1, 0, 0));
        tick(); nop(); push_exp(Z);
        tick(); nop(); push_exp(Z);

        // lw x7; add x8,x7,x0 -> one stall cycle, bubble, then select 10
        tick(); ins(7, 1, 0, 1, 0, 1, 1, 0, 1, 0); push_exp(Z);
        tick(); ins(8, 7, 0, 1, 1, 1, 0, 0, 0, 0); push_exp(mk(0, 0, 1, 0, 7, 1, 1, 0));
        tick(); ins(8, 7, 0, 1, 1, 1, 0, 0, 0, 0); push_exp(Z);
        tick(); nop();                             push_exp(mk(2, 0, 0, 0, 8, 1, 0, 0));
        tick(); nop(); push_exp(Z);
        tick(); nop(); push_exp(Z);
        tick(); nop(); push_exp(Z);

        // flush beats load-use: no stall, next EX is a bubble
        tick(); ins(9, 1, 0, 1, 0, 1, 1, 0, 1, 0); push_exp(Z);
        tick(); ins(1, 9, 0, 1, 0, 1, 0, 0, 0, 0); flush = 1; push_exp(mk(0, 0, 1, 0, 9, 1, 0, 0));
        tick(); nop(); push_exp(Z);
        tick(); nop(); push_exp(Z);
        tick(); nop(); push_exp(Z);

        // div x11 then add x12,x11: 3 hold cycles, div in EX for 4 cycles
        tick(); ins(11, 1, 2, 1, 1, 1, 0, 1, 0, 0); push_exp(Z);
        tick(); ins(12, 11, 0, 1, 0, 1, 0, 0, 0, 0); push_exp(mk(0, 0, 0, 0, 11, 1, 1, 1));
        tick(); ins(12, 11, 0, 1, 0, 1, 0, 0, 0, 0); flush = 1; push_exp(mk(0, 0, 0, 0, 11, 1, 1, 1));
        tick(); ins(12, 11, 0, 1, 0, 1, 0, 0, 0, 0); push_exp(mk(0, 0, 0, 0, 11, 1, 1, 1));
        tick(); ins(12, 11, 0, 1, 0, 1, 0, 0, 0, 0); push_exp(mk(0, 0, 0, 0, 11, 1, 0, 0));
        tick(); nop();                               push_exp(mk(1, 0, 0, 0, 12, 1, 0, 0));
        tick(); nop(); push_exp(Z);
        tick(); nop(); push_exp(Z);
        tick(); nop(); push_exp(Z);

        // reset in the middle of a multi-cycle op
        tick();
`ifdef HAZ_PERF_CNT_EN
        chk_perf(1, 3);
`endif
        ins(13, 1, 2, 1, 1, 1, 0, 1, 0, 1); push_exp(Z);
        tick(); nop();          push_exp(mk(0, 0, 0, 1, 13, 1, 1, 1));
        tick(); nop(); rst = 1; push_exp(Z);
        tick(); rst = 0; nop(); push_exp(Z);
`ifdef HAZ_PERF_CNT_EN
        chk_perf(0, 0);
`endif
        tick(); nop(); push_exp(Z);

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
